// File: rtl/ddr_pkg.sv
// Shared DDR4 controller types: request codes, CAS scheduler FSM states
// and the read/write class helper.
package ddr_pkg;

    localparam logic [2:0] RD_R  = 3'd1;
    localparam logic [2:0] RDA_R = 3'd2;
    localparam logic [2:0] WR_R  = 3'd3;
    localparam logic [2:0] WRA_R = 3'd4;

    typedef enum logic [1:0] {
        CAS_IDLE,
        CAS_WAIT,
        CAS_CMD
    } cas_sched_fsm_type;

    function automatic logic is_write_req(input logic [2:0] rw);
        return (rw == WR_R) || (rw == WRA_R);
    endfunction

endpackage

// File: rtl/ctrl_cas_sched_if.sv
// Request/issue bundle between the ACT stage, the CAS scheduler and the
// command encoder. The scheduler sits on the slave modport.
interface ctrl_cas_sched_if #(
    parameter int BG_W = 2
);
    logic            act_rdy;
    logic            no_act_rdy;
    logic [2:0]      act_rw;
    logic [BG_W-1:0] act_bg;
    logic [4:0]      CL;
    logic [4:0]      CWL;
    logic [4:0]      BL;
    logic [3:0]      tCCD_L;
    logic            cas_rdy;
    logic [2:0]      cas_req;
    logic [BG_W-1:0] cas_bg;
    logic            cas_idle;
    logic            q_full;
    logic            q_overflow;

    modport master (
        output act_rdy, no_act_rdy, act_rw, act_bg, CL, CWL, BL, tCCD_L,
        input  cas_rdy, cas_req, cas_bg, cas_idle, q_full, q_overflow
    );

    modport slave (
        input  act_rdy, no_act_rdy, act_rw, act_bg, CL, CWL, BL, tCCD_L,
        output cas_rdy, cas_req, cas_bg, cas_idle, q_full, q_overflow
    );
endinterface

// File: rtl/cas_track_fifo.sv
// DEPTH-entry in-order tracking queue; every slot's wait counter ages by one
// per cycle down to 0. Push/pop in one cycle; caller must not push when full.
module cas_track_fifo #(
    parameter int DEPTH = 8,
    parameter int BG_W  = 2,
    parameter int CNT_W = 6
) (
    input  logic             CK_t,
    input  logic             reset_n,
    input  logic             push_vld,
    input  logic [2:0]       push_rw,
    input  logic [BG_W-1:0]  push_bg,
    input  logic [CNT_W-1:0] push_wait,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [2:0]       head_rw,
    output logic [BG_W-1:0]  head_bg,
    output logic [CNT_W-1:0] head_wait
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [2:0]       rw_q   [DEPTH];
    logic [2:0]       rw_d   [DEPTH];
    logic [BG_W-1:0]  bg_q   [DEPTH];
    logic [BG_W-1:0]  bg_d   [DEPTH];
    logic [CNT_W-1:0] wait_q [DEPTH];
    logic [CNT_W-1:0] wait_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   cnt_q, cnt_d;

    always_comb begin
        rw_d     = rw_q;
        bg_d     = bg_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        // Free slots age too; harmless, and keeps the counter logic uniform.
        for (int i = 0; i < DEPTH; i++) begin
            wait_d[i] = (wait_q[i] != '0) ? wait_q[i] - CNT_W'(1) : '0;
        end
        if (push_vld) begin
            rw_d[wr_ptr_q]   = push_rw;
            bg_d[wr_ptr_q]   = push_bg;
            wait_d[wr_ptr_q] = push_wait;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        cnt_d = cnt_q + (PTR_W+1)'(push_vld) - (PTR_W+1)'(pop);
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                rw_q[i]   <= '0;
                bg_q[i]   <= '0;
                wait_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            rw_q     <= rw_d;
            bg_q     <= bg_d;
            wait_q   <= wait_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    assign full      = (cnt_q == (PTR_W+1)'(DEPTH));
    assign empty     = (cnt_q == '0);
    assign head_rw   = rw_q[rd_ptr_q];
    assign head_bg   = bg_q[rd_ptr_q];
    assign head_wait = wait_q[rd_ptr_q];

endmodule

// File: rtl/ctrl_cas_sched.sv
// Multi-entry CAS scheduler: queues ACT/row-hit notifications, ages tRCD per
// entry and issues one registered CAS strobe per entry in FIFO order under
// tCCD_S/L and read/write turnaround spacing.
module ctrl_cas_sched
    import ddr_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int BG_W    = 2,
    parameter int CNT_W   = 6,
    parameter int T_RCD   = 16,
    parameter int T_CCD_S = 4,
    parameter int T_WTR_S = 3,
    parameter int T_WTR_L = 9
) (
    input  logic                CK_t,
    input  logic                reset_n,
    ctrl_cas_sched_if.slave     bus
);
    localparam int SUM_W = CNT_W + 1;
    localparam logic [SUM_W-1:0] GAP_MAX = SUM_W'((1 << CNT_W) - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    cas_sched_fsm_type state_q, state_d;
    logic              cas_rdy_q, cas_rdy_d;
    logic [2:0]        cas_req_q, cas_req_d;
    logic [BG_W-1:0]   cas_bg_q, cas_bg_d;
    logic              overflow_q, overflow_d;
    logic              last_wr_q, last_wr_d;
    logic [BG_W-1:0]   last_bg_q, last_bg_d;
    logic [CNT_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic              push_req, push_vld, pop;
    logic              fifo_full, fifo_empty;
    logic [2:0]        head_rw;
    logic [BG_W-1:0]   head_bg;
    logic [CNT_W-1:0]  head_wait, push_wait;
    logic              same_bg, head_wr;
    logic [SUM_W-1:0]  tccd, rd2wr, wr2rd, req_gap, gap_nxt;

    assign push_req  = bus.act_rdy | bus.no_act_rdy;
    // A pop in the same cycle frees the slot the push needs.
    assign push_vld  = push_req & (~fifo_full | pop);
    assign push_wait = bus.act_rdy ? CNT_W'(T_RCD - 1) : '0;

    cas_track_fifo #(.DEPTH(DEPTH), .BG_W(BG_W), .CNT_W(CNT_W)) u_fifo (
        .CK_t      (CK_t),
        .reset_n   (reset_n),
        .push_vld  (push_vld),
        .push_rw   (bus.act_rw),
        .push_bg   (bus.act_bg),
        .push_wait (push_wait),
        .pop       (pop),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_rw   (head_rw),
        .head_bg   (head_bg),
        .head_wait (head_wait)
    );

    always_comb begin
        same_bg = (head_bg == last_bg_q);
        head_wr = is_write_req(head_rw);
        tccd    = same_bg ? SUM_W'(bus.tCCD_L) : SUM_W'(T_CCD_S);
        rd2wr   = SUM_W'(bus.CL) + SUM_W'(bus.BL >> 1) + SUM_W'(2);
        rd2wr   = (rd2wr > SUM_W'(bus.CWL)) ? rd2wr - SUM_W'(bus.CWL) : '0;
        wr2rd   = SUM_W'(bus.CWL) + SUM_W'(bus.BL >> 1)
                + (same_bg ? SUM_W'(T_WTR_L) : SUM_W'(T_WTR_S));
        if (head_wr == last_wr_q)  req_gap = tccd;
        else if (head_wr)          req_gap = (rd2wr > tccd) ? rd2wr : tccd;
        else                       req_gap = (wr2rd > tccd) ? wr2rd : tccd;
        // gap_cnt saturates, so a larger requirement could never be met.
        if (req_gap > GAP_MAX) req_gap = GAP_MAX;
        // Issuing on this edge puts the new CAS gap_cnt+1 cycles after the last.
        gap_nxt = {1'b0, gap_cnt_q} + SUM_W'(1);
        pop = (state_q == CAS_WAIT) && !fifo_empty && (head_wait == '0)
              && (gap_nxt >= req_gap);

        state_d    = state_q;
        cas_rdy_d  = pop;
        cas_req_d  = pop ? head_rw : '0;
        cas_bg_d   = pop ? head_bg : '0;
        last_wr_d  = pop ? head_wr : last_wr_q;
        last_bg_d  = pop ? head_bg : last_bg_q;
        gap_cnt_d  = pop ? '0 : ((gap_cnt_q == CNT_MAX) ? gap_cnt_q : gap_cnt_q + CNT_W'(1));
        overflow_d = overflow_q | (push_req & fifo_full & ~pop);
        case (state_q)
            CAS_IDLE: if (!fifo_empty) state_d = CAS_WAIT;
            CAS_WAIT: if (pop)         state_d = CAS_CMD;
            CAS_CMD:  state_d = fifo_empty ? CAS_IDLE : CAS_WAIT;
            default:  state_d = CAS_IDLE;
        endcase
    end

    always_ff @(posedge CK_t or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CAS_IDLE;
            cas_rdy_q  <= 1'b0;
            cas_req_q  <= '0;
            cas_bg_q   <= '0;
            overflow_q <= 1'b0;
            last_wr_q  <= 1'b0;
            last_bg_q  <= '0;
            gap_cnt_q  <= CNT_MAX;
        end else begin
            state_q    <= state_d;
            cas_rdy_q  <= cas_rdy_d;
            cas_req_q  <= cas_req_d;
            cas_bg_q   <= cas_bg_d;
            overflow_q <= overflow_d;
            last_wr_q  <= last_wr_d;
            last_bg_q  <= last_bg_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign bus.cas_rdy    = cas_rdy_q;
    assign bus.cas_req    = cas_req_q;
    assign bus.cas_bg     = cas_bg_q;
    assign bus.cas_idle   = (state_q == CAS_IDLE) && fifo_empty;
    assign bus.q_full     = fifo_full;
    assign bus.q_overflow = overflow_q;

endmodule

// File: tb/tb_ctrl_cas_sched.sv
// Directed scoreboard bench for ctrl_cas_sched: stimulus pushes expected CAS
// (edge, code, bank group) into a queue; a negedge monitor pops and compares.
module tb_ctrl_cas_sched;
    import ddr_pkg::*;

    typedef struct {
        int         cyc;
        logic [2:0] req;
        logic [1:0] bg;
    } exp_t;

    logic CK_t = 1'b0;
    logic reset_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_fail = 0;
    int   cas_seen = 0;
    exp_t sb[$];

    ctrl_cas_sched_if #(.BG_W(2)) bus ();

    ctrl_cas_sched dut (
        .CK_t    (CK_t),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 CK_t = ~CK_t;
    always @(posedge CK_t) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every CAS strobe must match the queue head; a head whose edge
    // has passed without a strobe is reported as missing.
    always @(negedge CK_t) begin
        if (reset_n) begin
            if (bus.cas_rdy) begin
                cas_seen++;
                n_cmp++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_cas: cyc=%0d req=%0d bg=%0d, none required",
                             cyc, bus.cas_req, bus.cas_bg);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    if (cyc != e.cyc || bus.cas_req != e.req || bus.cas_bg != e.bg) begin
                        n_fail++;
                        $display("FAIL cas_issue: cyc=%0d req=%0d bg=%0d, required cyc=%0d req=%0d bg=%0d",
                                 cyc, bus.cas_req, bus.cas_bg, e.cyc, e.req, e.bg);
                    end
                end
            end else if (sb.size() != 0 && sb[0].cyc < cyc) begin
                exp_t e;
                e = sb.pop_front();
                n_cmp++;
                n_fail++;
                $display("FAIL missing_cas: none by cyc=%0d, required cyc=%0d req=%0d bg=%0d",
                         cyc, e.cyc, e.req, e.bg);
            end
        end
    end

    // Drive at the negedge before edge k so the pulse is sampled at edge k.
    task automatic push_at(input int k, input bit act, input bit noact,
                           input logic [2:0] rw, input logic [1:0] bg);
        while (cyc < k - 1) @(negedge CK_t);
        bus.act_rdy    = act;
        bus.no_act_rdy = noact;
        bus.act_rw     = rw;
        bus.act_bg     = bg;
        @(negedge CK_t);
        bus.act_rdy    = 1'b0;
        bus.no_act_rdy = 1'b0;
    endtask

    task automatic expect_cas(input int k, input logic [2:0] rw, input logic [1:0] bg);
        exp_t e;
        e.cyc = k;
        e.req = rw;
        e.bg  = bg;
        sb.push_back(e);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge CK_t);
            n++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s_timeout: %0d CAS outstanding, required 0", name, sb.size());
            sb.delete();
        end
        repeat (40) @(negedge CK_t);
    endtask

    initial begin
        int t;
        int seen0;
        bus.act_rdy    = 1'b0;
        bus.no_act_rdy = 1'b0;
        bus.act_rw     = 3'd0;
        bus.act_bg     = 2'd0;
        bus.CL         = 5'd16;
        bus.CWL        = 5'd12;
        bus.BL         = 5'd8;
        bus.tCCD_L     = 4'd6;
        repeat (3) @(negedge CK_t);
        check("rst_cas_rdy", int'(bus.cas_rdy), 0);
        check("rst_cas_req", int'(bus.cas_req), 0);
        check("rst_cas_bg", int'(bus.cas_bg), 0);
        check("rst_cas_idle", int'(bus.cas_idle), 1);
        check("rst_q_full", int'(bus.q_full), 0);
        check("rst_q_overflow", int'(bus.q_overflow), 0);
        reset_n = 1'b1;
        repeat (5) @(negedge CK_t);

        // Single ACT: tRCD latency, idle drops while pending and returns after.
        t = cyc + 5;
        expect_cas(t + 16, RD_R, 2'd0);
        push_at(t, 1'b1, 1'b0, RD_R, 2'd0);
        while (cyc < t + 5) @(negedge CK_t);
        check("idle_pending", int'(bus.cas_idle), 0);
        while (cyc < t + 18) @(negedge CK_t);
        check("idle_after", int'(bus.cas_idle), 1);
        drain("single");

        // Different bank group: tCCD_S.
        t = cyc + 5;
        expect_cas(t + 16, RD_R, 2'd0);
        expect_cas(t + 20, RD_R, 2'd1);
        push_at(t, 1'b1, 1'b0, RD_R, 2'd0);
        push_at(t + 1, 1'b1, 1'b0, RD_R, 2'd1);
        drain("ccd_s");

        // Same bank group: tCCD_L.
        t = cyc + 5;
        expect_cas(t + 16, RD_R, 2'd0);
        expect_cas(t + 22, RD_R, 2'd0);
        push_at(t, 1'b1, 1'b0, RD_R, 2'd0);
        push_at(t + 1, 1'b1, 1'b0, RD_R, 2'd0);
        drain("ccd_l");

        // Read then write, row hits: 16-12+4+2 = 10.
        t = cyc + 5;
        expect_cas(t + 2, RD_R, 2'd0);
        expect_cas(t + 12, WR_R, 2'd0);
        push_at(t, 1'b0, 1'b1, RD_R, 2'd0);
        push_at(t + 1, 1'b0, 1'b1, WR_R, 2'd0);
        drain("rd2wr");

        // Write then read, same bank group: 12+4+9 = 25.
        t = cyc + 5;
        expect_cas(t + 2, WRA_R, 2'd0);
        expect_cas(t + 27, RD_R, 2'd0);
        push_at(t, 1'b0, 1'b1, WRA_R, 2'd0);
        push_at(t + 1, 1'b0, 1'b1, RD_R, 2'd0);
        drain("wtr_l");

        // Write then read, different bank group: 12+4+3 = 19.
        t = cyc + 5;
        expect_cas(t + 2, WR_R, 2'd0);
        expect_cas(t + 21, RDA_R, 2'd1);
        push_at(t, 1'b0, 1'b1, WR_R, 2'd0);
        push_at(t + 1, 1'b0, 1'b1, RDA_R, 2'd1);
        drain("wtr_s");

        // Both pulses together: act_rdy wins, a single entry with full tRCD.
        t = cyc + 5;
        expect_cas(t + 16, RDA_R, 2'd2);
        push_at(t, 1'b1, 1'b1, RDA_R, 2'd2);
        drain("both");

        // Nine pushes into eight slots: ninth dropped, overflow sticky.
        t = cyc + 5;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] rw;
            rw = (i % 2 == 1) ? RDA_R : RD_R;
            expect_cas(t + 16 + 4 * i, rw, 2'(i % 4));
            push_at(t + i, 1'b1, 1'b0, rw, 2'(i % 4));
            if (i == 6) check("not_full_at_7", int'(bus.q_full), 0);
        end
        check("full_at_8", int'(bus.q_full), 1);
        check("no_ovf_at_8", int'(bus.q_overflow), 0);
        push_at(t + 8, 1'b1, 1'b0, WR_R, 2'd3);
        check("ovf_at_9", int'(bus.q_overflow), 1);
        drain("overflow");
        check("ovf_sticky", int'(bus.q_overflow), 1);
        check("full_cleared", int'(bus.q_full), 0);

        // Reset with three entries pending: nothing issues afterwards.
        t = cyc + 5;
        push_at(t, 1'b1, 1'b0, RD_R, 2'd0);
        push_at(t + 1, 1'b1, 1'b0, WR_R, 2'd1);
        push_at(t + 2, 1'b1, 1'b0, RD_R, 2'd2);
        while (cyc < t + 5) @(negedge CK_t);
        check("pre_rst_idle", int'(bus.cas_idle), 0);
        reset_n = 1'b0;
        #1;
        check("mid_rst_cas_rdy", int'(bus.cas_rdy), 0);
        check("mid_rst_cas_req", int'(bus.cas_req), 0);
        check("mid_rst_cas_bg", int'(bus.cas_bg), 0);
        check("mid_rst_cas_idle", int'(bus.cas_idle), 1);
        check("mid_rst_q_full", int'(bus.q_full), 0);
        check("mid_rst_q_overflow", int'(bus.q_overflow), 0);
        repeat (2) @(negedge CK_t);
        reset_n = 1'b1;
        seen0 = cas_seen;
        repeat (40) @(negedge CK_t);
        check("post_rst_cas_count", cas_seen - seen0, 0);
        check("post_rst_idle", int'(bus.cas_idle), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
